// File: rtl/phy_rx_lane_merge.sv
// phy_rx_lane_merge: reassembles 32-bit words from two byte lanes over two cycles.
// Optional PHY_RX_WORD_COUNT_EN adds a 16-bit wrapping count of delivered words.
module phy_rx_lane_merge #(
  parameter int IDLE_LIMIT = 8
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in_0,
  input  logic [7:0]  data_in_1,
  input  logic        valid_in0,
  input  logic        valid_in1,
  output logic [31:0] data_output,
  output logic        valid_out,
  output logic        active_out,
  output logic        lane_error
`ifdef PHY_RX_WORD_COUNT_EN
  ,
  output logic [15:0] word_count
`endif
);
  typedef enum logic {IDLE, HI_RCVD} state_t;
  localparam logic [7:0] LIM = IDLE_LIMIT[7:0];
  state_t state, state_nx;
  logic [15:0] hold;
  logic [7:0] idle_cnt, idle_nx;
  logic both, none, load_hi, load_word, err;
  assign both = valid_in0 & valid_in1;
  assign none = ~(valid_in0 | valid_in1);
  always_ff @(posedge clk_4f or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = (state == IDLE && both) ? HI_RCVD : IDLE;
  always_comb begin
    load_hi = (state == IDLE) && both;
    load_word = (state == HI_RCVD) && both;
    err = (valid_in0 ^ valid_in1) | ((state == HI_RCVD) && none);
  end
  assign idle_nx = !none ? 8'd0 : (idle_cnt == LIM ? idle_cnt : idle_cnt + 8'd1);
  // hold keeps only the first-cycle bytes: {lane0 -> [31:24], lane1 -> [15:8]}
  always_ff @(posedge clk_4f or negedge reset)
    if (!reset) begin
      hold <= '0;
      data_output <= '0;
      valid_out <= 1'b0;
      active_out <= 1'b0;
      lane_error <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (load_hi) hold <= {data_in_0, data_in_1};
      if (load_word) data_output <= {hold[15:8], data_in_0, hold[7:0], data_in_1};
      valid_out <= load_word;
      lane_error <= lane_error | err;
      idle_cnt <= idle_nx;
      active_out <= load_word | (active_out & (idle_nx != LIM));
    end
`ifdef PHY_RX_WORD_COUNT_EN
  always_ff @(posedge clk_4f or negedge reset)
    if (!reset) word_count <= '0;
    else if (valid_out) word_count <= word_count + 16'd1;
`endif
endmodule
